// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding and BCD constants for the serial sequencer
// Contents: state_e (IDLE/RUN/FIX/DONE), BCD_NINE, BCD_CORR,
//           bcd_digit_ok() digit range check, bcd_nines() nines complement.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return d <= BCD_NINE;
  endfunction

  function automatic logic [3:0] bcd_nines(input logic [3:0] d);
    return BCD_NINE - d;
  endfunction

endpackage

// File: rtl/bcd_serial_sequencer_if.sv
// rtl/bcd_serial_sequencer_if.sv - request/result bundle for the BCD serial sequencer
// Signals: start, sub, a, b (requester -> sequencer);
//          busy, done, result, cout, err, neg (sequencer -> requester).
// Modports: master = requester side, slave = sequencer side.
interface bcd_serial_sequencer_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  err;
  logic                  neg;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, err, neg
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, err, neg
  );

endinterface

// File: rtl/bcd_digit_adder.sv
// rtl/bcd_digit_adder.sv - combinational single-digit BCD adder (shared datapath)
// Ports: a_i, b_i (4-bit BCD digits), cin_i (decimal carry in),
//        sum_o (4-bit BCD digit), cout_o (decimal carry out).
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] bin_sum;

  always_comb begin
    bin_sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    // Above nine the +6 correction wraps the low nibble back into 0..9.
    if (bin_sum > 5'd9) begin
      sum_o  = bin_sum[3:0] + BCD_CORR;
      cout_o = 1'b1;
    end else begin
      sum_o  = bin_sum[3:0];
      cout_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_sequencer.sv
// rtl/bcd_serial_sequencer.sv - multi-digit BCD add/sub, one digit per clock through one adder
// Ports: clk, rst (synchronous, active-high), bus (bcd_serial_sequencer_if.slave).
// Optional macro BCD_SIGN_MAG_EN: adds the FIX state that turns a negative
// difference into magnitude with neg=1; without it neg is tied to 0.
module bcd_serial_sequencer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  bcd_serial_sequencer_if.slave    bus
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   c_q, c_d;
  logic                   sub_q, sub_d;
  logic                   cout_q, cout_d;
  logic                   err_q, err_d;
  logic [DIGITS-1:0][3:0] a_q, a_d;
  logic [DIGITS-1:0][3:0] b_q, b_d;
  logic [DIGITS-1:0][3:0] res_q, res_d;
`ifdef BCD_SIGN_MAG_EN
  logic                   neg_q, neg_d;
`endif

  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       in_err;

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_ok(bus.a[4*i +: 4]) || !bcd_digit_ok(bus.b[4*i +: 4])) begin
        in_err = 1'b1;
      end
    end
  end

  // Adder operand mux: RUN adds A to B (or to B's nines complement for
  // subtraction); FIX adds 0 to the nines complement of the stored result.
  always_comb begin
    add_a   = a_q[k_q];
    add_b   = sub_q ? bcd_nines(b_q[k_q]) : b_q[k_q];
    add_cin = c_q;
`ifdef BCD_SIGN_MAG_EN
    if (state_q == ST_FIX) begin
      add_a = 4'd0;
      add_b = bcd_nines(res_q[k_q]);
    end
`endif
  end

  bcd_digit_adder u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    err_d   = err_q;
`ifdef BCD_SIGN_MAG_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d    = bus.a;
          b_d    = bus.b;
          sub_d  = bus.sub;
          k_d    = '0;
          // Subtraction's +1 of the tens complement enters as the first carry.
          c_d    = bus.sub;
          res_d  = '0;
          cout_d = 1'b0;
          err_d  = in_err;
`ifdef BCD_SIGN_MAG_EN
          neg_d  = 1'b0;
`endif
          state_d = in_err ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[k_q] = add_sum;
        c_d        = add_cout;
        k_d        = k_q + 1'b1;
        if (k_q == K_LAST) begin
          cout_d  = add_cout;
          k_d     = '0;
          state_d = ST_DONE;
`ifdef BCD_SIGN_MAG_EN
          // No carry out of a subtraction means A<B: negate to magnitude.
          if (sub_q && !add_cout) begin
            c_d     = 1'b1;
            state_d = ST_FIX;
          end
`endif
        end
      end
`ifdef BCD_SIGN_MAG_EN
      ST_FIX: begin
        res_d[k_q] = add_sum;
        c_d        = add_cout;
        k_d        = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          neg_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SIGN_MAG_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
`ifdef BCD_SIGN_MAG_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.err    = err_q;
`ifdef BCD_SIGN_MAG_EN
  assign bus.neg    = neg_q;
`else
  assign bus.neg    = 1'b0;
`endif

endmodule
